// File: rtl/dac_sound_sequencer.sv
// dac_sound_sequencer: arbitrates three game-event sound requests and plays square-wave bursts on the DAC level.
//
// Ports:
//   CLK        system clock
//   nReset     asynchronous active-low reset
//   ReqScore   score event pulse, highest priority
//   ReqHit     paddle-hit event pulse, middle priority
//   ReqWall    wall-bounce event pulse, lowest priority
//   Mute       force mid-scale output; sequencing continues
//   DAC_Level  registered 8-bit level for the DAC input
//   Grant      one-hot {Wall,Hit,Score} of the burst on DAC_Level
//   Busy       high while a burst or its trailing gap is in progress
//
// Optional feature macro: DAC_SEQ_PREEMPT_EN
//   defined   - a strictly higher-priority pending request aborts the current burst or gap
//   undefined - bursts and gaps always run to completion
module dac_sound_sequencer #(
    parameter int          HALF_W     = 12,
    parameter int          LEN_W      = 8,
    parameter int          HIT_HALF   = 1000,
    parameter int          WALL_HALF  = 2000,
    parameter int          SCORE_HALF = 500,
    parameter int          HIT_LEN    = 40,
    parameter int          WALL_LEN   = 20,
    parameter int          SCORE_LEN  = 120,
    parameter logic [7:0]  AMP        = 8'h30,
    parameter int          GAP_LEN    = 256
) (
    input  logic       CLK,
    input  logic       nReset,
    input  logic       ReqScore,
    input  logic       ReqHit,
    input  logic       ReqWall,
    input  logic       Mute,
    output logic [7:0] DAC_Level,
    output logic [2:0] Grant,
    output logic       Busy
);
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [2:0]        pend_q, pend_d;
    logic [2:0]        cur_q, cur_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              phase_q, phase_d;
    logic [7:0]        dac_q, dac_d;
    logic [2:0]        grant_q, grant_d;
    logic              busy_q, busy_d;

    logic [2:0]        sel;
    logic [HALF_W-1:0] sel_half, cur_half;
    logic [LEN_W-1:0]  sel_len;
    logic              preempt;
    logic              start;

    always_comb begin
        sel      = pend_q[0] ? 3'b001 : pend_q[1] ? 3'b010 : pend_q[2] ? 3'b100 : 3'b000;
        sel_half = sel[0] ? HALF_W'(SCORE_HALF - 1) : sel[1] ? HALF_W'(HIT_HALF - 1) : HALF_W'(WALL_HALF - 1);
        cur_half = cur_q[0] ? HALF_W'(SCORE_HALF - 1) : cur_q[1] ? HALF_W'(HIT_HALF - 1) : HALF_W'(WALL_HALF - 1);
        sel_len  = sel[0] ? LEN_W'(SCORE_LEN) : sel[1] ? LEN_W'(HIT_LEN) : LEN_W'(WALL_LEN);
`ifdef DAC_SEQ_PREEMPT_EN
        // cur_q - 1 masks the bits above the current grant in priority; with
        // cur_q cleared during GAP the mask is all ones, so any request wins.
        preempt  = (state_q != S_IDLE) && |(pend_q & (cur_q - 3'd1));
`else
        preempt  = 1'b0;
`endif
        start    = ((state_q == S_IDLE) && |pend_q) || preempt;
        // A request in the clearing cycle re-sets its bit so the sound replays.
        pend_d   = (pend_q & ~(start ? sel : 3'b000)) | {ReqWall, ReqHit, ReqScore};
        state_d  = state_q;
        cur_d    = cur_q;
        half_d   = half_q;
        len_d    = len_q;
        gap_d    = gap_q;
        phase_d  = phase_q;
        if (start) begin
            state_d = S_PLAY;
            cur_d   = sel;
            half_d  = sel_half;
            len_d   = sel_len;
            phase_d = 1'b1;
        end else if (state_q == S_PLAY) begin
            half_d = (half_q == '0) ? cur_half : half_q - 1'b1;
            if (half_q == '0) begin
                phase_d = ~phase_q;
                len_d   = len_q - 1'b1;
                if (len_q == LEN_W'(1)) begin
                    state_d = S_GAP;
                    gap_d   = GAP_W'(GAP_LEN - 1);
                    cur_d   = 3'b000;
                end
            end
        end else if (state_q == S_GAP) begin
            state_d = (gap_q == '0) ? S_IDLE : S_GAP;
            gap_d   = (gap_q == '0) ? gap_q : gap_q - 1'b1;
        end
        // Outputs are registered from the current state so Grant and Busy stay
        // aligned with the level they describe.
        dac_d   = (state_q == S_PLAY && !Mute) ? (phase_q ? 8'h80 + AMP : 8'h80 - AMP) : 8'h80;
        grant_d = cur_q;
        busy_d  = state_q != S_IDLE;
    end

    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            cur_q   <= '0;
            half_q  <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            phase_q <= 1'b0;
            dac_q   <= 8'h80;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            half_q  <= half_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            phase_q <= phase_d;
            dac_q   <= dac_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign DAC_Level = dac_q;
    assign Grant     = grant_q;
    assign Busy      = busy_q;
endmodule

// File: tb/tb_dac_sound_sequencer.sv
// tb_dac_sound_sequencer: scoreboard bench for dac_sound_sequencer with short tones.
module tb_dac_sound_sequencer;
    logic       CLK = 1'b0;
    logic       nReset = 1'b0;
    logic       ReqScore = 1'b0;
    logic       ReqHit = 1'b0;
    logic       ReqWall = 1'b0;
    logic       Mute = 1'b0;
    logic [7:0] DAC_Level;
    logic [2:0] Grant;
    logic       Busy;

    typedef struct packed {
        logic [7:0] dac;
        logic [2:0] grant;
        logic       busy;
    } exp_t;

    localparam exp_t IDLE = {8'h80, 3'b000, 1'b0};

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    dac_sound_sequencer #(
        .HALF_W(12), .LEN_W(8),
        .HIT_HALF(4), .WALL_HALF(6), .SCORE_HALF(2),
        .HIT_LEN(3), .WALL_LEN(2), .SCORE_LEN(4),
        .AMP(8'h20), .GAP_LEN(3)
    ) dut (
        .CLK(CLK), .nReset(nReset),
        .ReqScore(ReqScore), .ReqHit(ReqHit), .ReqWall(ReqWall), .Mute(Mute),
        .DAC_Level(DAC_Level), .Grant(Grant), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    task automatic push(input exp_t x, input int n);
        repeat (n) q.push_back(x);
    endtask

    // A burst alternates 0xA0/0x60 per half-period, then three silent busy cycles.
    task automatic push_burst(input logic [2:0] g);
        int half, len;
        half = (g == 3'b001) ? 2 : (g == 3'b010) ? 4 : 6;
        len  = (g == 3'b001) ? 4 : (g == 3'b010) ? 3 : 2;
        for (int i = 0; i < len; i++) push({(i % 2 == 0) ? 8'hA0 : 8'h60, g, 1'b1}, half);
        push({8'h80, 3'b000, 1'b1}, 3);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge CLK);
        checks++;
        if ({DAC_Level, Grant, Busy} !== IDLE) begin
            errors++;
            $display("FAIL reset got dac=%h grant=%b busy=%b exp dac=80 grant=000 busy=0", DAC_Level, Grant, Busy);
        end
        nReset = 1'b1;
    endtask

    task automatic test_single_hit;
        int n;
        push(IDLE, 3);
        push_burst(3'b010);
        n = q.size() + 3;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            if (q.size() != 0) e = q.pop_front(); else e = IDLE;
            checks++;
            if ({DAC_Level, Grant, Busy} !== e) begin
                errors++;
                $display("FAIL single_hit c=%0d got dac=%h grant=%b busy=%b exp dac=%h grant=%b busy=%b", c, DAC_Level, Grant, Busy, e.dac, e.grant, e.busy);
            end
            ReqHit = (c == 0);
        end
    endtask

    task automatic test_simultaneous;
        int n;
        push(IDLE, 3);
        push_burst(3'b001);
        push(IDLE, 1);
        push_burst(3'b010);
        push(IDLE, 1);
        push_burst(3'b100);
        n = q.size() + 3;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            if (q.size() != 0) e = q.pop_front(); else e = IDLE;
            checks++;
            if ({DAC_Level, Grant, Busy} !== e) begin
                errors++;
                $display("FAIL simultaneous c=%0d got dac=%h grant=%b busy=%b exp dac=%h grant=%b busy=%b", c, DAC_Level, Grant, Busy, e.dac, e.grant, e.busy);
            end
            ReqScore = (c == 0);
            ReqHit   = (c == 0);
            ReqWall  = (c == 0);
        end
    endtask

    task automatic test_repeat_merge;
        int n;
        push(IDLE, 3);
        push_burst(3'b010);
        push(IDLE, 1);
        push_burst(3'b010);
        n = q.size() + 3;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            if (q.size() != 0) e = q.pop_front(); else e = IDLE;
            checks++;
            if ({DAC_Level, Grant, Busy} !== e) begin
                errors++;
                $display("FAIL repeat_merge c=%0d got dac=%h grant=%b busy=%b exp dac=%h grant=%b busy=%b", c, DAC_Level, Grant, Busy, e.dac, e.grant, e.busy);
            end
            ReqHit = (c == 0) || (c == 4) || (c == 6) || (c == 8);
        end
    endtask

    task automatic test_mute;
        int n;
        push(IDLE, 3);
        push_burst(3'b001);
        n = q.size() + 3;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            if (q.size() != 0) e = q.pop_front(); else e = IDLE;
            // Mute sampled at the previous edge forces mid-scale only.
            if (Mute) e.dac = 8'h80;
            checks++;
            if ({DAC_Level, Grant, Busy} !== e) begin
                errors++;
                $display("FAIL mute c=%0d got dac=%h grant=%b busy=%b exp dac=%h grant=%b busy=%b", c, DAC_Level, Grant, Busy, e.dac, e.grant, e.busy);
            end
            ReqScore = (c == 0);
            Mute     = (c >= 4) && (c <= 7);
        end
    endtask

    task automatic test_preempt;
        int n;
        push(IDLE, 3);
`ifdef DAC_SEQ_PREEMPT_EN
        push({8'hA0, 3'b100, 1'b1}, 5);
        push_burst(3'b001);
`else
        push_burst(3'b100);
        push(IDLE, 1);
        push_burst(3'b001);
`endif
        n = q.size() + 3;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            if (q.size() != 0) e = q.pop_front(); else e = IDLE;
            checks++;
            if ({DAC_Level, Grant, Busy} !== e) begin
                errors++;
                $display("FAIL preempt c=%0d got dac=%h grant=%b busy=%b exp dac=%h grant=%b busy=%b", c, DAC_Level, Grant, Busy, e.dac, e.grant, e.busy);
            end
            ReqWall  = (c == 0);
            ReqScore = (c == 5);
        end
    endtask

    task automatic test_reset_mid_burst;
        push(IDLE, 3);
        push_burst(3'b010);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (q.size() != 0) e = q.pop_front(); else e = IDLE;
            checks++;
            if ({DAC_Level, Grant, Busy} !== e) begin
                errors++;
                $display("FAIL reset_mid pre c=%0d got dac=%h grant=%b busy=%b exp dac=%h grant=%b busy=%b", c, DAC_Level, Grant, Busy, e.dac, e.grant, e.busy);
            end
            ReqHit  = (c == 0);
            ReqWall = (c == 6);
        end
        nReset = 1'b0;
        #1;
        checks++;
        if ({DAC_Level, Grant, Busy} !== IDLE) begin
            errors++;
            $display("FAIL reset_mid async got dac=%h grant=%b busy=%b exp dac=80 grant=000 busy=0", DAC_Level, Grant, Busy);
        end
        repeat (2) @(negedge CLK);
        nReset = 1'b1;
        q.delete();
        for (int c = 0; c < 25; c++) begin
            @(negedge CLK);
            checks++;
            if ({DAC_Level, Grant, Busy} !== IDLE) begin
                errors++;
                $display("FAIL reset_mid post c=%0d got dac=%h grant=%b busy=%b exp dac=80 grant=000 busy=0", c, DAC_Level, Grant, Busy);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_hit;
        test_simultaneous;
        test_repeat_merge;
        test_mute;
        test_preempt;
        test_reset_mid_burst;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
